uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side bit-timing controller for the UART Rx path. It oversamples the serial line, detects and qualifies the start bit, and majority-votes each bit at mid-period. It drives the LSB-first deserializer with a one-cycle shift strobe per data bit, then checks parity and stop bit and flags a completed frame. It sits between the synchronised `rx_in` pin and the deserializer / Rx output register.

## Interface
- `DATA_W`, 8, data bits per frame; also the number of `deser_en` pulses per frame.
- `PRESCALE_W`, 6, width of the `prescale` input.
- `clk` in 1, system clock (oversampling clock).
- `reset` in 1, reset, asynchronous, active-low.
- `rx_in` in 1, serial line, already synchronised to `clk`, idle high.
- `prescale` in PRESCALE_W, oversampling ratio; legal values 8, 16, 32; latched on frame start.
- `par_en` in 1, parity bit present; latched on frame start.
- `par_typ` in 1, 0 = even, 1 = odd; latched on frame start.
- `sampled_bit` out 1, majority-voted value of the current bit; reset 1.
- `deser_en` out 1, one-cycle shift strobe to the deserializer, DATA bits only; reset 0.
- `data_valid` out 1, one-cycle pulse for an error-free frame; reset 0.
- `par_err` out 1, parity mismatch in the last frame; reset 0.
- `stp_err` out 1, stop bit sampled low in the last frame; reset 0.

## Operation
- Counters:
  - `edge_cnt` runs 0..P-1, where P is the latched prescale; it wraps to 0 at each bit boundary.
  - `bit_cnt` runs 0..DATA_W-1 in DATA.
  - h = P/2.
- Sampling:
  - `rx_in` is captured at `edge_cnt` = h-1, h and h+1.
  - At `edge_cnt` = h+2, `sampled_bit` takes the 2-of-3 majority.
  - The cycle at `edge_cnt` = h+3 is the bit's strobe cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - `rx_in`==0 → START.
    - Set `edge_cnt`=0.
    - Latch `prescale`, `par_en` and `par_typ`.
    - Clear `par_err`, `stp_err` and the running parity.
  - START:
    - At the strobe cycle, if `sampled_bit`==1 → IDLE as a glitch, with no outputs.
    - Otherwise, at `edge_cnt`=P-1 → DATA.
  - DATA:
    - At the strobe cycle, `deser_en`=1 and running parity ^= `sampled_bit`.
    - At `edge_cnt`=P-1: if `bit_cnt`=DATA_W-1 → PARITY (when `par_en`) or STOP; otherwise `bit_cnt`++.
  - PARITY:
    - At the strobe cycle, set `par_err` = `sampled_bit` ^ running parity ^ `par_typ`.
    - At `edge_cnt`=P-1 → STOP.
  - STOP:
    - At the strobe cycle, set `stp_err` = ~`sampled_bit`.
    - `data_valid` = `sampled_bit` & ~`par_err`.
    - Go to IDLE in the same cycle. This gives ~half a bit of margin, so back-to-back frames resynchronise on the next falling edge.
- `par_err` and `stp_err` hold until the next IDLE→START transition.
- `deser_en` never pulses in START, PARITY or STOP. Exactly DATA_W pulses occur per accepted frame.
- Mid-frame changes to `prescale`, `par_en` and `par_typ` are ignored.
- Reset mid-frame forces IDLE, all counters to 0 and all outputs to their reset values within the same cycle (async).

## Timing
- `sampled_bit` changes one full cycle before `deser_en` rises. The deserializer clocks on the `deser_en` rising edge, so its data input is always settled.
- Frame start to first `deser_en`: P + h + 3 cycles after the cycle in which `rx_in` is first seen low in IDLE.
- Successive `deser_en` pulses are exactly P cycles apart.
- `data_valid` rises at stop-bit `edge_cnt`=h+3, lasts one cycle, and the deserializer holds the byte at that point.
- Prescale values below 8 or not a power of two are unsupported, and behaviour with them is undefined.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state, running parity and `par_err` logic are built, and `par_en`/`par_typ` behave as above.
  - Undefined: `par_en` and `par_typ` are ignored, DATA goes directly to STOP, and `par_err` is tied to 0.

## Structure
- Shared package `uart_rx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-type constants PAR_EVEN=0 and PAR_ODD=1;
  - the legal prescale constants 8, 16 and 32.
- One sub-module, `uart_rx_sampler`: the three-sample capture plus majority vote, keyed on `edge_cnt` and h, producing `sampled_bit`.
- The FSM and counters stay in `uart_rx_ctrl`.

## Test plan
- P=8, no parity, frame 0xA5 (LSB first):
  - `deser_en` pulses 8 times, 8 cycles apart.
  - The `sampled_bit` sequence at the pulses is 1,0,1,0,0,1,0,1.
  - Deserializer holds 0xA5, `data_valid` pulses once, and both error flags are 0.
- P=16, even parity, 0x03 with parity bit 1: `par_err`=1, `data_valid` stays 0. Repeat with parity bit 0: `data_valid`=1.
- P=8, odd parity, 0x00 with parity 1 and stop bit driven 0: `stp_err`=1, `par_err`=0, no `data_valid`.
- Start glitch, with `rx_in` low for 2 cycles then high, P=8: FSM returns to IDLE, no `deser_en`, no flags set.
- Single-cycle inversion of `rx_in` at `edge_cnt`=h within data bit 3 of 0xFF: the majority vote still yields 1 and the byte is 0xFF.
- `reset` asserted after the 4th `deser_en`, then a full 0x3C frame: outputs are at reset values immediately, and the next frame receives 0x3C cleanly with `data_valid`=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART Rx bit-timing controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Two-of-three vote used for each bit's mid-period samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures rx_in at h-1, h, h+1 of each bit and registers the majority vote,
// so sampled_bit is valid from edge_cnt = h+2 onward.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic [CNT_W-1:0] edge_cnt,
  input  logic [CNT_W-1:0] half,
  output logic             sampled_bit
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      sampled_bit <= 1'b1;
    end else begin
      if (edge_cnt == half - CNT_W'(1)) s0_q <= rx_in;
      if (edge_cnt == half)             s1_q <= rx_in;
      // Third sample is taken live so the vote lands one cycle earlier.
      if (edge_cnt == half + CNT_W'(1)) sampled_bit <= maj3(s0_q, s1_q, rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART Rx bit-timing controller: start qualification, per-bit strobes,
// parity and stop checking. Parity support is built when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  sampled_bit,
  output logic                  deser_en,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  deser_en_d;
  logic                  data_valid_d;
  logic                  stp_err_d;

  logic [PRESCALE_W-1:0] half;
  logic                  bit_end;
  logic                  strobe;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic run_par_q, run_par_d;
  logic par_err_d;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = ^{par_en, par_typ};
  assign par_err        = 1'b0;
`endif

  assign half    = p_q >> 1;
  assign bit_end = (edge_q == p_q - PRESCALE_W'(1));
  // Decisions are made the cycle before the strobe so outputs are registered into it.
  assign strobe  = (edge_q == half + PRESCALE_W'(2));

  uart_rx_sampler #(
    .CNT_W (PRESCALE_W)
  ) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .edge_cnt    (edge_q),
    .half        (half),
    .sampled_bit (sampled_bit)
  );

  always_comb begin
    state_d      = state_q;
    edge_d       = edge_q;
    bit_d        = bit_q;
    p_d          = p_q;
    deser_en_d   = 1'b0;
    data_valid_d = 1'b0;
    stp_err_d    = stp_err;
`ifdef UART_RX_PARITY_EN
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    run_par_d    = run_par_q;
    par_err_d    = par_err;
`endif

    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : edge_q + PRESCALE_W'(1);
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        p_d    = prescale_legal(32'(prescale)) ? prescale : PRESCALE_W'(PRESCALE_8);
`ifdef UART_RX_PARITY_EN
        par_en_d  = par_en;
        par_typ_d = par_typ;
`endif
        // The cycle rx_in is first seen low counts as edge 0 of the start bit.
        if (!rx_in) begin
          state_d   = START;
          edge_d    = PRESCALE_W'(1);
          stp_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          run_par_d = 1'b0;
          par_err_d = 1'b0;
`endif
        end
      end

      START: begin
        if (strobe && sampled_bit) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (strobe) begin
          deser_en_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          run_par_d  = run_par_q ^ sampled_bit;
`endif
        end
        if (bit_end) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (strobe) begin
          par_err_d = sampled_bit ^ run_par_q ^ (par_typ_q == PAR_ODD);
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (strobe) begin
          stp_err_d    = ~sampled_bit;
          data_valid_d = sampled_bit & ~par_err;
          state_d      = IDLE;
          edge_d       = '0;
        end
      end

      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      p_q        <= PRESCALE_W'(PRESCALE_8);
      deser_en   <= 1'b0;
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      run_par_q  <= 1'b0;
      par_err    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      p_q        <= p_d;
      deser_en   <= deser_en_d;
      data_valid <= data_valid_d;
      stp_err    <= stp_err_d;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      run_par_q  <= run_par_d;
      par_err    <= par_err_d;
`endif
    end
  end

endmodule
